dsp_mac_pipe: RTL

//  Parametrised successor to the fixed 18x18/48-bit DSP slice. Datapath: pre-adder/subtractor, signed multiplier, post-adder/subtractor.

---
 rtl/dsp_pkg.sv | 20 ++
 rtl/dsp_pipe_reg.sv | 19 +
 rtl/dsp_mac_pipe.sv | 90 +++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// dsp_pkg: OPMODE bit indices, X/Z mux encodings and saturation limit helper for dsp_mac_pipe
package dsp_pkg;
  localparam int OP_POST = 7;
  localparam int OP_PRE = 6;
  localparam int OP_CY = 5;
  localparam int OP_USEPRE = 4;
  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M = 2'b01;
  localparam logic [1:0] X_P = 2'b10;
  localparam logic [1:0] X_DAB = 2'b11;
  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_PCIN = 2'b01;
  localparam logic [1:0] Z_P = 2'b10;
  localparam logic [1:0] Z_C = 2'b11;
  function automatic logic [63:0] sat_lim(input logic neg, input int unsigned w);
    logic [63:0] max;
    max = (64'd1 << (w - 1)) - 64'd1;
    return neg ? ~max : max;
  endfunction
endpackage

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: W-bit pipeline stage (clk, rst async, ce hold, d -> q), EN=0 makes it a wire
module dsp_pipe_reg #(
  parameter int W = 1,
  parameter int EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (EN != 0) begin : g_reg
    always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (ce) q <= d;
  end else begin : g_byp
    assign q = d;
  end
endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: pre-add, signed multiply, post-add MAC (A/B/D/C/PCIN/CARRYIN/OPMODE in; BCOUT/M/P/PCOUT/CARRYOUT/OVF/out_valid out)
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int CW = 48,
  parameter int PW = 48,
  parameter int IREG = 1,
  parameter int MREG = 1,
  parameter int PREG = 1,
  parameter int CYSRC = 0,
  parameter int SAT_EN = 0
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             CE,
  input  logic             in_valid,
  input  logic [AW-1:0]    A,
  input  logic [BW-1:0]    B,
  input  logic [BW-1:0]    D,
  input  logic [CW-1:0]    C,
  input  logic [PW-1:0]    PCIN,
  input  logic             CARRYIN,
  input  logic [7:0]       OPMODE,
  output logic [BW-1:0]    BCOUT,
  output logic [AW+BW-1:0] M,
  output logic [PW-1:0]    P,
  output logic [PW-1:0]    PCOUT,
  output logic             CARRYOUT,
  output logic             CARRYOUTF,
  output logic             OVF,
  output logic             out_valid
);
  localparam int S1W = AW + 2 * BW + CW + 9;
  localparam int S2W = 2 * AW + 3 * BW + CW + 7;
  logic [AW-1:0] a1, a2;
  logic [BW-1:0] b1, d1, b2, d2, pre, bm;
  logic [CW-1:0] c1, c2;
  logic [7:0] op1;
  logic ci1, ci2, post2, cy2, v1, v2, v3, cin, ovf, co, co3, ovf3;
  logic [1:0] xsel2, zsel2;
  logic [AW+BW-1:0] prod, m2;
  logic [PW-1:0] xv, zv, pn, p3;
  logic [PW+1:0] xs, zs, ss;
  dsp_pipe_reg #(.W(S1W), .EN(IREG)) u_s1 (
    .clk(clk), .rst(RST), .ce(CE),
    .d({A, B, D, C, OPMODE, CARRYIN}),
    .q({a1, b1, d1, c1, op1, ci1})
  );
  dsp_pipe_reg #(.W(1), .EN(IREG)) u_v1 (.clk(clk), .rst(RST), .ce(CE), .d(in_valid), .q(v1));
  dsp_pipe_reg #(.W(S2W), .EN(MREG)) u_s2 (
    .clk(clk), .rst(RST), .ce(CE),
    .d({prod, a1, b1, d1, c1, op1[OP_POST], op1[OP_CY], op1[3:0], ci1}),
    .q({m2, a2, b2, d2, c2, post2, cy2, zsel2, xsel2, ci2})
  );
  dsp_pipe_reg #(.W(1), .EN(MREG)) u_v2 (.clk(clk), .rst(RST), .ce(CE), .d(v1), .q(v2));
  dsp_pipe_reg #(.W(PW + 2), .EN(PREG)) u_s3 (
    .clk(clk), .rst(RST), .ce(CE),
    .d({co, ovf, pn}),
    .q({co3, ovf3, p3})
  );
  dsp_pipe_reg #(.W(1), .EN(PREG)) u_v3 (.clk(clk), .rst(RST), .ce(CE), .d(v2), .q(v3));
  always_comb begin
    pre = op1[OP_PRE] ? d1 - b1 : d1 + b1;
    bm = op1[OP_USEPRE] ? pre : b1;
    prod = $signed({{BW{a1[AW-1]}}, a1}) * $signed({{AW{bm[BW-1]}}, bm});
    xv = xsel2 == X_M ? PW'($signed(m2)) :
         xsel2 == X_P ? p3 :
         xsel2 == X_DAB ? PW'({d2, a2, b2}) : '0;
    zv = zsel2 == Z_PCIN ? PCIN :
         zsel2 == Z_P ? p3 :
         zsel2 == Z_C ? PW'($signed(c2)) : '0;
    cin = CYSRC != 0 ? cy2 : ci2;
    xs = {{2{xv[PW-1]}}, xv} + (PW + 2)'(cin);
    zs = {{2{zv[PW-1]}}, zv};
    ss = post2 ? zs - xs : zs + xs;
    ovf = ss[PW+1:PW-1] != 3'b000 && ss[PW+1:PW-1] != 3'b111;
    co = ss[PW] ^ zv[PW-1] ^ xv[PW-1];
    pn = (SAT_EN != 0 && ovf) ? PW'(sat_lim(ss[PW+1], PW)) : ss[PW-1:0];
  end
  assign BCOUT = bm;
  assign M = m2;
  assign P = p3;
  assign PCOUT = p3;
  assign CARRYOUT = co3;
  assign CARRYOUTF = co3;
  assign OVF = ovf3;
  assign out_valid = v3;
endmodule
